// File: rtl/imm_pkg.sv
// Shared types, opcode constants and the sign-extension helper for the
// pipelined immediate generator.
package imm_pkg;

   typedef enum logic [2:0] {
      FMT_NONE = 3'd0,
      FMT_I    = 3'd1,
      FMT_S    = 3'd2,
      FMT_B    = 3'd3,
      FMT_U    = 3'd4,
      FMT_J    = 3'd5,
      FMT_R    = 3'd6,
      FMT_SH   = 3'd7
   } fmt_e;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } occ_e;

   localparam logic [6:0] OPC_LOAD      = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
   localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] OPC_STORE     = 7'b0100011;
   localparam logic [6:0] OPC_OP        = 7'b0110011;
   localparam logic [6:0] OPC_LUI       = 7'b0110111;
   localparam logic [6:0] OPC_OP_32     = 7'b0111011;
   localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
   localparam logic [6:0] OPC_JALR      = 7'b1100111;
   localparam logic [6:0] OPC_JAL       = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

   // All formats assemble a 32-bit value whose bit 31 is instr[31].
   function automatic logic [63:0] sext32(input logic [31:0] v);
      return {{32{v[31]}}, v};
   endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Upstream/downstream handshake bundle of the immediate generator.
interface imm_gen_pipe_if import imm_pkg::*; #(
   parameter int XLEN = 32
) ();
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_instr;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_imm;
   fmt_e            out_fmt;
   logic            out_illegal;
   logic [31:0]     out_instr;

   modport slave (
      input  in_valid, in_instr, out_ready,
      output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_instr
   );

   modport master (
      output in_valid, in_instr, out_ready,
      input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_instr
   );
endinterface

// File: rtl/imm_decode.sv
// Combinational opcode decode: instruction word to extended immediate,
// format code and illegal flag.
module imm_decode import imm_pkg::*; #(
   parameter int XLEN = 32,
   parameter bit RV64 = (XLEN == 64)
) (
   input  logic [31:0]     i_instr,
   output logic [XLEN-1:0] o_imm,
   output fmt_e            o_fmt,
   output logic            o_illegal
);
   logic [6:0]  w_opc;
   logic [2:0]  w_funct3;
   logic        w_is_shift;
   logic [31:0] w_imm32;
   logic [31:0] w_imm_i;
   logic [31:0] w_shamt_w;
   logic [31:0] w_shamt_x;

   assign w_opc      = i_instr[6:0];
   assign w_funct3   = i_instr[14:12];
   assign w_is_shift = (w_funct3 == 3'b001) || (w_funct3 == 3'b101);
   assign w_imm_i    = {{20{i_instr[31]}}, i_instr[31:20]};
   assign w_shamt_w  = {27'd0, i_instr[24:20]};
   // OP-IMM shifts take a 6-bit shamt only on a 64-bit datapath.
   assign w_shamt_x  = (XLEN == 64) ? {26'd0, i_instr[25:20]} : w_shamt_w;

   always_comb begin
      w_imm32   = '0;
      o_fmt     = FMT_NONE;
      o_illegal = 1'b0;
      case (w_opc)
         OPC_LOAD, OPC_JALR, OPC_SYSTEM: begin
            o_fmt   = FMT_I;
            w_imm32 = w_imm_i;
         end
         OPC_OP_IMM: begin
            o_fmt   = w_is_shift ? FMT_SH : FMT_I;
            w_imm32 = w_is_shift ? w_shamt_x : w_imm_i;
         end
         OPC_OP_IMM_32: begin
            if (RV64) begin
               o_fmt   = w_is_shift ? FMT_SH : FMT_I;
               w_imm32 = w_is_shift ? w_shamt_w : w_imm_i;
            end else begin
               o_illegal = 1'b1;
            end
         end
         OPC_STORE: begin
            o_fmt   = FMT_S;
            w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
         end
         OPC_BRANCH: begin
            o_fmt   = FMT_B;
            w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                       i_instr[30:25], i_instr[11:8], 1'b0};
         end
         OPC_LUI, OPC_AUIPC: begin
            o_fmt   = FMT_U;
            w_imm32 = {i_instr[31:12], 12'h000};
         end
         OPC_JAL: begin
            o_fmt   = FMT_J;
            w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                       i_instr[20], i_instr[30:21], 1'b0};
         end
         OPC_OP: o_fmt = FMT_R;
         OPC_OP_32: begin
            if (RV64) o_fmt = FMT_R;
            else      o_illegal = 1'b1;
         end
         default: o_illegal = 1'b1;
      endcase
   end

   assign o_imm = XLEN'(sext32(w_imm32));
endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator: decode on the input side, then a
// two-entry (MAIN + SKID) buffer behind a valid/ready handshake.
module imm_gen_pipe import imm_pkg::*; #(
   parameter int XLEN = 32,
   parameter bit RV64 = (XLEN == 64)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           flush,
   imm_gen_pipe_if.slave  bus
);
   occ_e            r_state;
   occ_e            w_state_next;
   logic [XLEN-1:0] w_dec_imm;
   fmt_e            w_dec_fmt;
   logic            w_dec_ill;
   logic [XLEN-1:0] r_main_imm, r_skid_imm;
   fmt_e            r_main_fmt, r_skid_fmt;
   logic            r_main_ill, r_skid_ill;
   logic [31:0]     r_main_instr, r_skid_instr;
   logic            w_in_xfer;
   logic            w_out_xfer;

   imm_decode #(.XLEN(XLEN), .RV64(RV64)) u_decode (
      .i_instr   (bus.in_instr),
      .o_imm     (w_dec_imm),
      .o_fmt     (w_dec_fmt),
      .o_illegal (w_dec_ill)
   );

   assign w_in_xfer  = bus.in_valid && bus.in_ready;
   assign w_out_xfer = bus.out_valid && bus.out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_EMPTY;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      if (flush) begin
         w_state_next = ST_EMPTY;
      end else begin
         case (r_state)
            ST_EMPTY: if (w_in_xfer) w_state_next = ST_ONE;
            ST_ONE: begin
               if (w_in_xfer && !w_out_xfer)      w_state_next = ST_TWO;
               else if (!w_in_xfer && w_out_xfer) w_state_next = ST_EMPTY;
            end
            ST_TWO:  if (w_out_xfer) w_state_next = ST_ONE;
            default: w_state_next = ST_EMPTY;
         endcase
      end
   end

   // Entry data needs no clearing on flush: out_valid masks stale contents.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_main_imm   <= '0;
         r_main_fmt   <= FMT_NONE;
         r_main_ill   <= 1'b0;
         r_main_instr <= '0;
         r_skid_imm   <= '0;
         r_skid_fmt   <= FMT_NONE;
         r_skid_ill   <= 1'b0;
         r_skid_instr <= '0;
      end else if (!flush) begin
         if ((r_state == ST_EMPTY && w_in_xfer) ||
             (r_state == ST_ONE && w_in_xfer && w_out_xfer)) begin
            r_main_imm   <= w_dec_imm;
            r_main_fmt   <= w_dec_fmt;
            r_main_ill   <= w_dec_ill;
            r_main_instr <= bus.in_instr;
         end else if (r_state == ST_TWO && w_out_xfer) begin
            r_main_imm   <= r_skid_imm;
            r_main_fmt   <= r_skid_fmt;
            r_main_ill   <= r_skid_ill;
            r_main_instr <= r_skid_instr;
         end
         if (r_state == ST_ONE && w_in_xfer && !w_out_xfer) begin
            r_skid_imm   <= w_dec_imm;
            r_skid_fmt   <= w_dec_fmt;
            r_skid_ill   <= w_dec_ill;
            r_skid_instr <= bus.in_instr;
         end
      end
   end

   always_comb begin
      bus.in_ready    = (r_state != ST_TWO);
      bus.out_valid   = (r_state != ST_EMPTY);
      bus.out_imm     = r_main_imm;
      bus.out_fmt     = r_main_fmt;
      bus.out_illegal = r_main_ill;
      bus.out_instr   = r_main_instr;
   end
endmodule
